// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default geometry and the word-count acceptance rule.
package loader_pkg;

    localparam int LOADER_ADDR_W    = 12;
    localparam int LOADER_MAX_WORDS = 4096;
    localparam int BYTES_PER_WORD   = 4;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        CSUM,
        RUN,
        ERROR
    } loader_state_e;

    // A program must hold at least one word and fit in instruction memory.
    function automatic logic count_ok(input logic [15:0] cnt, input int max_words);
        return (cnt != 16'd0) && ({16'd0, cnt} <= $unsigned(max_words));
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian host bytes into 32-bit instruction words; the
// word_valid strobe is registered so it lands the cycle after the 4th byte.
module imem_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic [1:0]  byte_idx_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] word_q;
    logic        word_valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_q[8*gi +: 8] <= 8'd0;
                end else if (byte_valid_i && (byte_idx_i == 2'(gi))) begin
                    word_q[8*gi +: 8] <= byte_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= byte_valid_i && (byte_idx_i == 2'(BYTES_PER_WORD - 1));
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a counted, checksummed program over a byte stream,
// writes it into instruction memory and releases the core on success.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = LOADER_ADDR_W,
    parameter int MAX_WORDS = LOADER_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    loader_state_e     state_q;
    logic [7:0]        cnt_lo_q;
    logic [15:0]       count_q;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [7:0]        csum_q;
    logic [ADDR_W-1:0] addr_q;
    logic              core_rst_n_q;
    logic              done_q;
    logic              err_q;

    logic              xfer;
    logic              data_xfer;
    logic [15:0]       count_d;
    logic [7:0]        csum_d;
    logic              last_word_d;

    assign rx_ready = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                      (state_q == DATA)   || (state_q == CSUM);
    assign xfer        = rx_valid && rx_ready;
    assign data_xfer   = xfer && (state_q == DATA);
    assign count_d     = {rx_data, cnt_lo_q};
    assign csum_d      = csum_q ^ rx_data;
    assign last_word_d = (32'(word_cnt_q) + 32'd1) == 32'(count_q);

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid_i (data_xfer),
        .byte_idx_i   (byte_cnt_q),
        .byte_i       (rx_data),
        .word_o       (imem_wdata),
        .word_valid_o (imem_we)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= CNT_LO;
            cnt_lo_q     <= 8'd0;
            count_q      <= 16'd0;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= '0;
            csum_q       <= 8'd0;
            addr_q       <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                CNT_LO: begin
                    if (xfer) begin
                        cnt_lo_q <= rx_data;
                        state_q  <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (xfer) begin
                        count_q <= count_d;
                        if (count_ok(count_d, MAX_WORDS)) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum_q     <= csum_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // Address is latched with the final byte so it lines up with the packer strobe.
                        if (byte_cnt_q == 2'd3) begin
                            addr_q     <= word_cnt_q[ADDR_W-1:0];
                            word_cnt_q <= word_cnt_q + 1'b1;
                            if (last_word_d) begin
                                state_q <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        if (rx_data == csum_q) begin
                            state_q      <= RUN;
                            core_rst_n_q <= 1'b1;
                            done_q       <= 1'b1;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RUN, ERROR: begin
                    if (load_req) begin
                        state_q      <= CNT_LO;
                        cnt_lo_q     <= 8'd0;
                        count_q      <= 16'd0;
                        byte_cnt_q   <= 2'd0;
                        word_cnt_q   <= '0;
                        csum_q       <= 8'd0;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CNT_LO;
                end
            endcase
        end
    end

    assign imem_addr  = addr_q;
    assign core_rst_n = core_rst_n_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory word-address width.
REQ-002 Parameter MAX_WORDS, default 4096, largest accepted program length in words.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_valid  input  1  host byte valid.
REQ-006 rx_data  input  8  host byte.
REQ-007 rx_ready  output  1  loader accepts byte; a transfer occurs on a cycle where rx_valid and rx_ready are both high.
REQ-008 load_req  input  1  single-cycle pulse requesting a reload.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  output  32  instruction word.
REQ-012 core_rst_n  output  1  active-low reset to the core; low holds PC at 0.
REQ-013 done  output  1  program loaded and core running.
REQ-014 err  output  1  load failed; core held in reset.

Function
REQ-015 The host stream SHALL be: count_lo, count_hi (16-bit word count, little-endian), then count*4 payload bytes (each word little-endian), then one checksum byte.
REQ-016 The FSM states SHALL be CNT_LO, CNT_HI, DATA, CSUM, RUN and ERROR.
REQ-017 rx_ready SHALL be 1 in CNT_LO, CNT_HI, DATA and CSUM, and 0 in RUN and ERROR.
REQ-018 The loader SHALL accept one byte per cycle with no bubbles when rx_valid stays high, and SHALL tolerate arbitrary gaps in rx_valid.
REQ-019 On a transfer in CNT_HI, a count of 0 or a count greater than MAX_WORDS SHALL cause a transition to ERROR; any other count SHALL cause a transition to DATA.
REQ-020 In DATA, byte k of a word SHALL occupy bits [8k+7:8k]; a 2-bit byte counter and an ADDR_W+1-bit word counter SHALL track position.
REQ-021 On the cycle after the 4th byte of word n is transferred, imem_we SHALL be 1 for exactly one cycle, with imem_addr = n and imem_wdata = the assembled word.
REQ-022 imem_we SHALL be 0 at all other times.
REQ-023 After the last byte of word count-1, the FSM SHALL move to CSUM.
REQ-024 The running checksum SHALL be the XOR of all payload bytes; count bytes SHALL be excluded.
REQ-025 On a transfer in CSUM, a match SHALL cause a transition to RUN and a mismatch SHALL cause a transition to ERROR.
REQ-026 core_rst_n SHALL be 1 only in RUN and SHALL rise on the cycle after the checksum transfer, so the final imem write completes first.
REQ-027 done SHALL equal (state == RUN) and err SHALL equal (state == ERROR), both registered.
REQ-028 A load_req in RUN or ERROR SHALL force core_rst_n low on the next cycle, clear the checksum and counters, and enter CNT_LO.
REQ-029 A load_req in any other state SHALL be ignored.
REQ-030 If load_req and a transfer coincide, the transfer SHALL take precedence.
REQ-031 The word counter SHALL never wrap: MAX_WORDS words SHALL write addresses 0 to MAX_WORDS-1 exactly.

Reset
REQ-032 While rst_n = 0 at a clock edge, state SHALL become CNT_LO and all counters and the checksum SHALL clear.
REQ-033 Under reset, core_rst_n=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0 and err=0.
REQ-034 Reset mid-load SHALL discard the partial word and SHALL NOT issue a write.

Structure
REQ-035 The state enum and the MAX_WORDS and ADDR_W defaults SHALL live in shared package loader_pkg.
REQ-036 Byte-to-word assembly SHALL be a sub-module imem_word_packer (byte in, 32-bit word plus word_valid out); the FSM, counters and checksum SHALL stay in imem_loader.

Verification
REQ-037 Stream 02 00 13 00 00 00 78 56 34 12 1B -> writes (0,0x00000013) then (1,0x12345678); the cycle after the 0x1B transfer, core_rst_n=1 and done=1.
REQ-038 Same stream with checksum 0x1C -> both writes occur; err=1 and core_rst_n stays 0; rx_ready=0.
REQ-039 Count 00 00 -> ERROR after the 2nd byte with no writes; count 01 10 (4097) -> ERROR with no writes.
REQ-040 Test-vector stream delivered with random 0-3 cycle rx_valid gaps -> identical writes and the same final state.
REQ-041 load_req while done=1 -> core_rst_n=0 on the next cycle, rx_ready=1, done=0; a new stream loads and runs.
REQ-042 rst_n low after 6 payload bytes -> only write 0 issued; after release a fresh full stream loads correctly.
